// File: rtl/dfx_seq_regmap_pkg.sv
// Register-map definitions shared by the DFX sequencer AXI-Lite read and write slaves.
// Holds bus/field widths, address-map bit positions, bank select codes, bank0 slot
// codes, bank1 field codes, AXI response codes, the slave state encoding and the
// read-beat payload struct.
package dfx_seq_regmap_pkg;

    // Bus and field widths
    localparam int unsigned GLOB_ADDR_WIDTH      = 32;
    localparam int unsigned ADDR_WIDTH           = 16;
    localparam int unsigned DATA_WIDTH           = 32;
    localparam int unsigned RESP_WIDTH           = 2;
    localparam int unsigned BANK1_INDEX_WIDTH    = 2;
    localparam int unsigned BANK1_SRC_ADDR_WIDTH = 32;
    localparam int unsigned BANK1_SRC_SIZE_WIDTH = 26;
    localparam int unsigned BANK1_DST_ADDR_WIDTH = 32;
    localparam int unsigned BANK1_DST_SIZE_WIDTH = 26;
    localparam int unsigned BANK1_STATUS_WIDTH   = 2;
    localparam int unsigned BANK1_PROFILE_WIDTH  = 32;
    localparam int unsigned BANK0_CONTROL_WIDTH  = 4;
    localparam int unsigned BANK0_STATUS_WIDTH   = 4;
    localparam int unsigned BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH;

    // Byte-address bit positions of the map fields
    localparam int unsigned ADDR_LSB        = 2;   // bits below this select a byte lane and are ignored
    localparam int unsigned WORD_ADDR_WIDTH = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned BANK_SEL_LSB    = 14;
    localparam int unsigned BANK_SEL_WIDTH  = 2;
    localparam int unsigned B0_SLOT_LSB     = 6;
    localparam int unsigned B0_SLOT_WIDTH   = 8;
    localparam int unsigned B1_ROW_LSB      = 6;
    localparam int unsigned B1_FIELD_LSB    = 2;
    localparam int unsigned B1_FIELD_WIDTH  = 4;

    // Bank select codes (address bits [15:14])
    localparam logic [BANK_SEL_WIDTH-1:0] BANK_SEL_B0 = 2'b00;
    localparam logic [BANK_SEL_WIDTH-1:0] BANK_SEL_B1 = 2'b01;

    // Bank0 slot codes (address bits [13:6])
    localparam logic [B0_SLOT_WIDTH-1:0] B0_SLOT_CONTROL   = 8'h00;
    localparam logic [B0_SLOT_WIDTH-1:0] B0_SLOT_STATUS    = 8'h01;
    localparam logic [B0_SLOT_WIDTH-1:0] B0_SLOT_CUR_CNT   = 8'h02;
    localparam logic [B0_SLOT_WIDTH-1:0] B0_SLOT_END_CNT   = 8'h03;
    localparam logic [B0_SLOT_WIDTH-1:0] B0_SLOT_DMA_BASE  = 8'h04;
    localparam logic [B0_SLOT_WIDTH-1:0] B0_SLOT_DFX_CTRL  = 8'h05;

    // Bank1 field codes (address bits [5:2])
    localparam logic [B1_FIELD_WIDTH-1:0] B1_FIELD_SRC_ADDR = 4'd0;
    localparam logic [B1_FIELD_WIDTH-1:0] B1_FIELD_SRC_SIZE = 4'd1;
    localparam logic [B1_FIELD_WIDTH-1:0] B1_FIELD_DES_ADDR = 4'd2;
    localparam logic [B1_FIELD_WIDTH-1:0] B1_FIELD_DES_SIZE = 4'd3;
    localparam logic [B1_FIELD_WIDTH-1:0] B1_FIELD_STATUS   = 4'd4;
    localparam logic [B1_FIELD_WIDTH-1:0] B1_FIELD_PROFILE  = 4'd5;

    // AXI response codes
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

    // Slave state encoding; unused codes recover to ST_IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RESP  = 3'd2
    } rd_state_e;

    // One R-channel beat
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
    } rd_beat_t;

endpackage

// File: rtl/s_axi_read_if.sv
// AXI4-Lite read channels (AR + R) between the PS interconnect and the read slave.
// master: drives ARADDR/ARVALID/RREADY; slave: drives ARREADY/RDATA/RRESP/RVALID.
interface s_axi_read_if;
    import dfx_seq_regmap_pkg::*;

    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] S_AXI_RDATA;
    logic [RESP_WIDTH-1:0] S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport master (
        output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/s_axi_read_mux.sv
// Combinational register-file read decoder.
// i_word_addr : captured read address with byte-lane bits dropped
// i_bank0_*   : bank0 control/status/counters/base addresses
// i_bank1_*   : slot fields of the row already selected by the captured address
// o_beat_c    : zero-extended field value and OKAY, or zero data and SLVERR if unmapped
module s_axi_read_mux
    import dfx_seq_regmap_pkg::*;
(
    input  logic [WORD_ADDR_WIDTH-1:0]      i_word_addr,
    input  logic [BANK0_CONTROL_WIDTH-1:0]  i_bank0_control,
    input  logic [BANK0_STATUS_WIDTH-1:0]   i_bank0_status,
    input  logic [BANK0_CNT_WIDTH-1:0]      i_bank0_cur_cnt,
    input  logic [BANK0_CNT_WIDTH-1:0]      i_bank0_end_cnt,
    input  logic [GLOB_ADDR_WIDTH-1:0]      i_bank0_dma_base,
    input  logic [GLOB_ADDR_WIDTH-1:0]      i_bank0_dfx_ctrl,
    input  logic [BANK1_SRC_ADDR_WIDTH-1:0] i_bank1_src_addr,
    input  logic [BANK1_SRC_SIZE_WIDTH-1:0] i_bank1_src_size,
    input  logic [BANK1_DST_ADDR_WIDTH-1:0] i_bank1_des_addr,
    input  logic [BANK1_DST_SIZE_WIDTH-1:0] i_bank1_des_size,
    input  logic [BANK1_STATUS_WIDTH-1:0]   i_bank1_status,
    input  logic [BANK1_PROFILE_WIDTH-1:0]  i_bank1_profile,
    output rd_beat_t                        o_beat_c
);

    logic [BANK_SEL_WIDTH-1:0] w_bank_sel;
    logic [B0_SLOT_WIDTH-1:0]  w_slot;
    logic [B1_FIELD_WIDTH-1:0] w_field;
    logic [DATA_WIDTH-1:0]     w_value;
    logic                      w_hit;

    // Map fields, re-based to the word address
    assign w_bank_sel = i_word_addr[BANK_SEL_LSB-ADDR_LSB +: BANK_SEL_WIDTH];
    assign w_slot     = i_word_addr[B0_SLOT_LSB-ADDR_LSB  +: B0_SLOT_WIDTH];
    assign w_field    = i_word_addr[B1_FIELD_LSB-ADDR_LSB +: B1_FIELD_WIDTH];

    // Field select; anything not explicitly mapped is a miss
    always_comb begin
        w_value = '0;
        w_hit   = 1'b1;
        case (w_bank_sel)
            BANK_SEL_B0: begin
                case (w_slot)
                    B0_SLOT_CONTROL:  w_value = DATA_WIDTH'(i_bank0_control);
                    B0_SLOT_STATUS:   w_value = DATA_WIDTH'(i_bank0_status);
                    B0_SLOT_CUR_CNT:  w_value = DATA_WIDTH'(i_bank0_cur_cnt);
                    B0_SLOT_END_CNT:  w_value = DATA_WIDTH'(i_bank0_end_cnt);
                    B0_SLOT_DMA_BASE: w_value = DATA_WIDTH'(i_bank0_dma_base);
                    B0_SLOT_DFX_CTRL: w_value = DATA_WIDTH'(i_bank0_dfx_ctrl);
                    default:          w_hit   = 1'b0;
                endcase
            end
            BANK_SEL_B1: begin
                case (w_field)
                    B1_FIELD_SRC_ADDR: w_value = DATA_WIDTH'(i_bank1_src_addr);
                    B1_FIELD_SRC_SIZE: w_value = DATA_WIDTH'(i_bank1_src_size);
                    B1_FIELD_DES_ADDR: w_value = DATA_WIDTH'(i_bank1_des_addr);
                    B1_FIELD_DES_SIZE: w_value = DATA_WIDTH'(i_bank1_des_size);
                    B1_FIELD_STATUS:   w_value = DATA_WIDTH'(i_bank1_status);
                    B1_FIELD_PROFILE:  w_value = DATA_WIDTH'(i_bank1_profile);
                    default:           w_hit   = 1'b0;
                endcase
            end
            default: w_hit = 1'b0;
        endcase
        o_beat_c.data = w_hit ? w_value : '0;
        o_beat_c.resp = w_hit ? RESP_OKAY : RESP_SLVERR;
    end

endmodule

// File: rtl/s_axi_read.sv
// AXI4-Lite read slave for the DFX sequencer register file.
// clk, reset           : clock, asynchronous active-low reset
// s_axi                : AR/R channels (slave modport)
// ext_bank1_out_index  : slot row addressed by the captured read address
// ext_bank1_*          : slot fields of that row, valid combinationally
// ext_bank0_*          : control/status/counters/base addresses
// One read outstanding: IDLE accepts AR, FETCH samples the banks, RESP holds R until RREADY.
module s_axi_read
    import dfx_seq_regmap_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    s_axi_read_if.slave                     s_axi,
    output logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_out_index,
    input  logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_src_addr,
    input  logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_src_size,
    input  logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_des_addr,
    input  logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_des_size,
    input  logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_status,
    input  logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_profile,
    input  logic [BANK0_CONTROL_WIDTH-1:0]  ext_bank0_control,
    input  logic [BANK0_STATUS_WIDTH-1:0]   ext_bank0_status,
    input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_curCnt,
    input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_endCnt,
    input  logic [GLOB_ADDR_WIDTH-1:0]      ext_bank0_dmaBaseAddr,
    input  logic [GLOB_ADDR_WIDTH-1:0]      ext_bank0_dfxCtrlAddr
);

    rd_state_e                  r_state;
    logic [WORD_ADDR_WIDTH-1:0] r_read_addr;   // byte-lane bits are never decoded, so not stored
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic [RESP_WIDTH-1:0]      r_rresp;
    logic                       r_arready;
    logic                       r_rvalid;
    rd_beat_t                   w_beat;

    // Field decode of the captured address against the live bank inputs
    s_axi_read_mux u_mux (
        .i_word_addr      (r_read_addr),
        .i_bank0_control  (ext_bank0_control),
        .i_bank0_status   (ext_bank0_status),
        .i_bank0_cur_cnt  (ext_bank0_curCnt),
        .i_bank0_end_cnt  (ext_bank0_endCnt),
        .i_bank0_dma_base (ext_bank0_dmaBaseAddr),
        .i_bank0_dfx_ctrl (ext_bank0_dfxCtrlAddr),
        .i_bank1_src_addr (ext_bank1_src_addr),
        .i_bank1_src_size (ext_bank1_src_size),
        .i_bank1_des_addr (ext_bank1_des_addr),
        .i_bank1_des_size (ext_bank1_des_size),
        .i_bank1_status   (ext_bank1_status),
        .i_bank1_profile  (ext_bank1_profile),
        .o_beat_c         (w_beat)
    );

    // Read FSM with registered handshake and data outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_read_addr <= '0;
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
            r_arready   <= 1'b1;
            r_rvalid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_axi.S_AXI_ARVALID) begin
                        r_read_addr <= s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
                        r_arready   <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Only sampling point of the bank inputs for this read
                    r_rdata  <= w_beat.data;
                    r_rresp  <= w_beat.resp;
                    r_rvalid <= 1'b1;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;

    // Row select is byte-address bits [7:6], i.e. word-address bits [5:4]
    assign ext_bank1_out_index = r_read_addr[B1_ROW_LSB-ADDR_LSB +: BANK1_INDEX_WIDTH];

endmodule

// File: tb/tb_s_axi_read.sv
// Self-checking bench for s_axi_read: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized reads.
module tb_s_axi_read;
    import dfx_seq_regmap_pkg::*;

    logic clk;
    logic reset;
    s_axi_read_if axi ();

    logic [1:0]  ext_bank1_out_index;
    logic [31:0] ext_bank1_src_addr, ext_bank1_des_addr, ext_bank1_profile;
    logic [25:0] ext_bank1_src_size, ext_bank1_des_size;
    logic [1:0]  ext_bank1_status;
    logic [3:0]  b0_control, b0_status;
    logic [1:0]  b0_cur, b0_end;
    logic [31:0] b0_dma, b0_dfx;

    // Slot table, indexed by the row the DUT asks for
    logic [31:0] t_src_addr [4];
    logic [25:0] t_src_size [4];
    logic [31:0] t_des_addr [4];
    logic [25:0] t_des_size [4];
    logic [1:0]  t_status   [4];
    logic [31:0] t_profile  [4];

    assign ext_bank1_src_addr = t_src_addr[ext_bank1_out_index];
    assign ext_bank1_src_size = t_src_size[ext_bank1_out_index];
    assign ext_bank1_des_addr = t_des_addr[ext_bank1_out_index];
    assign ext_bank1_des_size = t_des_size[ext_bank1_out_index];
    assign ext_bank1_status   = t_status[ext_bank1_out_index];
    assign ext_bank1_profile  = t_profile[ext_bank1_out_index];

    s_axi_read dut (
        .clk                   (clk),
        .reset                 (reset),
        .s_axi                 (axi),
        .ext_bank1_out_index   (ext_bank1_out_index),
        .ext_bank1_src_addr    (ext_bank1_src_addr),
        .ext_bank1_src_size    (ext_bank1_src_size),
        .ext_bank1_des_addr    (ext_bank1_des_addr),
        .ext_bank1_des_size    (ext_bank1_des_size),
        .ext_bank1_status      (ext_bank1_status),
        .ext_bank1_profile     (ext_bank1_profile),
        .ext_bank0_control     (b0_control),
        .ext_bank0_status      (b0_status),
        .ext_bank0_curCnt      (b0_cur),
        .ext_bank0_endCnt      (b0_end),
        .ext_bank0_dmaBaseAddr (b0_dma),
        .ext_bank0_dfxCtrlAddr (b0_dfx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int scramble_mode = 0;   // 0: banks static, 1: all banks change every cycle

    // Reference model state
    logic        m_arready, m_rvalid, m_fetch_pend;
    logic [15:0] m_addr;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    bit          hs_ar, hs_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {resp, data} for a byte address, from the register map
    function automatic logic [33:0] expect_beat(input logic [15:0] a);
        int unsigned bank, slot, field, row;
        bank  = 32'(a) >> 14;
        slot  = (32'(a) >> 6) & 32'hFF;
        field = (32'(a) >> 2) & 32'hF;
        row   = (32'(a) >> 6) & 32'h3;
        expect_beat = {2'b10, 32'h0};
        if (bank == 0) begin
            case (slot)
                0: expect_beat = {2'b00, 32'(b0_control)};
                1: expect_beat = {2'b00, 32'(b0_status)};
                2: expect_beat = {2'b00, 32'(b0_cur)};
                3: expect_beat = {2'b00, 32'(b0_end)};
                4: expect_beat = {2'b00, b0_dma};
                5: expect_beat = {2'b00, b0_dfx};
                default: ;
            endcase
        end else if (bank == 1) begin
            case (field)
                0: expect_beat = {2'b00, t_src_addr[row]};
                1: expect_beat = {2'b00, 32'(t_src_size[row])};
                2: expect_beat = {2'b00, t_des_addr[row]};
                3: expect_beat = {2'b00, 32'(t_des_size[row])};
                4: expect_beat = {2'b00, 32'(t_status[row])};
                5: expect_beat = {2'b00, t_profile[row]};
                default: ;
            endcase
        end
    endfunction

    task automatic model_reset();
        m_arready = 1'b1; m_rvalid = 1'b0; m_fetch_pend = 1'b0;
        m_addr = '0; m_rdata = '0; m_rresp = '0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        hs_ar = 1'b0; hs_r = 1'b0;
        if (m_fetch_pend) begin
            {m_rresp, m_rdata} = expect_beat(m_addr);
            m_rvalid = 1'b1; m_fetch_pend = 1'b0;
        end else if (m_rvalid) begin
            if (axi.S_AXI_RREADY) begin
                m_rvalid = 1'b0; m_arready = 1'b1; hs_r = 1'b1;
            end
        end else if (m_arready && axi.S_AXI_ARVALID) begin
            m_addr = axi.S_AXI_ARADDR; m_arready = 1'b0; m_fetch_pend = 1'b1; hs_ar = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("arready", 64'(axi.S_AXI_ARREADY), 64'(m_arready));
        chk("rvalid",  64'(axi.S_AXI_RVALID),  64'(m_rvalid));
        chk("rdata",   64'(axi.S_AXI_RDATA),   64'(m_rdata));
        chk("rresp",   64'(axi.S_AXI_RRESP),   64'(m_rresp));
        chk("b1_index", 64'(ext_bank1_out_index), 64'(m_addr[7:6]));
    endtask

    task automatic scramble();
        b0_control = 4'($urandom); b0_status = 4'($urandom);
        b0_cur = 2'($urandom); b0_end = 2'($urandom);
        b0_dma = $urandom; b0_dfx = $urandom;
        for (int i = 0; i < 4; i++) begin
            t_src_addr[i] = $urandom; t_src_size[i] = 26'($urandom);
            t_des_addr[i] = $urandom; t_des_size[i] = 26'($urandom);
            t_status[i] = 2'($urandom); t_profile[i] = $urandom;
        end
    endtask

    // One clock: compare just after the edge, then allow the caller to drive
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) model_edge();
        check_all();
        if (scramble_mode == 1) scramble();
    endtask

    // Full read: AR, wait for R, optional backpressure, R handshake
    task automatic do_read(input logic [15:0] addr, input int stall, input bit noise,
                           input bit stall_status_churn,
                           output logic [31:0] d, output logic [1:0] r,
                           output logic [1:0] idx, output int lat, output logic [31:0] d_end);
        bit got;
        d = '0; r = '0; idx = '0; lat = 0; d_end = '0;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_ARADDR  = addr;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (hs_ar) got = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout: no AR handshake for addr %h", addr);
            axi.S_AXI_ARVALID = 1'b0;
            return;
        end
        // Extra AR traffic while busy must be ignored
        axi.S_AXI_ARVALID = noise ? 1'($urandom) : 1'b0;
        axi.S_AXI_ARADDR  = noise ? 16'($urandom) : addr;
        got = 0; lat = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (noise) axi.S_AXI_RREADY = 1'($urandom);
            step();
            lat++;
            if (axi.S_AXI_RVALID) got = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL r_timeout: no RVALID for addr %h", addr);
            axi.S_AXI_ARVALID = 1'b0;
            return;
        end
        d = axi.S_AXI_RDATA; r = axi.S_AXI_RRESP; idx = ext_bank1_out_index;
        axi.S_AXI_RREADY = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (stall_status_churn) b0_status = 4'($urandom);
            step();
        end
        d_end = axi.S_AXI_RDATA;
        axi.S_AXI_RREADY = 1'b1;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            step();
            if (hs_r) got = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL r_hs_timeout: R handshake missing for addr %h", addr);
        end
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = noise ? 1'($urandom) : 1'b0;
    endtask

    logic [31:0] d, d_end;
    logic [1:0]  r, idx;
    int          lat;
    logic [15:0] a;

    initial begin
        reset = 1'b0;
        axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_ARADDR = '0; axi.S_AXI_RREADY = 1'b0;
        scramble();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_arready", 64'(axi.S_AXI_ARREADY), 64'd1);
        chk("reset_rvalid",  64'(axi.S_AXI_RVALID),  64'd0);
        chk("reset_rdata",   64'(axi.S_AXI_RDATA),   64'd0);
        chk("reset_rresp",   64'(axi.S_AXI_RRESP),   64'd0);
        #3 reset = 1'b1;
        step();

        // endCnt through bank0 slot 3, latency check
        b0_end = 2'd3;
        do_read(16'h00C0, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("tp1_data", 64'(d), 64'h3);
        chk("tp1_resp", 64'(r), 64'h0);
        chk("tp1_latency", 64'(lat), 64'd2);

        // Slot 2 destination address
        t_des_addr[2] = 32'hDEADBEEF;
        do_read(16'h4088, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("tp2_index", 64'(idx), 64'd2);
        chk("tp2_data", 64'(d), 64'hDEADBEEF);
        chk("tp2_resp", 64'(r), 64'h0);

        // 26-bit field zero-extended
        t_src_size[1] = 26'h3FFFFFF;
        do_read(16'h4044, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("tp3_data", 64'(d), 64'h03FFFFFF);

        // Unmapped bank then a mapped read
        do_read(16'h8000, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("tp4_err_data", 64'(d), 64'h0);
        chk("tp4_err_resp", 64'(r), 64'h2);
        b0_dma = 32'h40000000;
        do_read(16'h0100, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("tp4_ok_resp", 64'(r), 64'h0);
        chk("tp4_ok_data", 64'(d), 64'h40000000);

        // Unmapped bank0 slot and bank1 field
        do_read(16'h0180, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("b0_slot6_resp", 64'(r), 64'h2);
        do_read(16'h4018, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("b1_field6_resp", 64'(r), 64'h2);

        // Backpressure with churn on bank0 status after the sample point
        b0_status = 4'hA;
        do_read(16'h0043, 10, 1'b0, 1'b1, d, r, idx, lat, d_end);
        chk("tp5_data_first", 64'(d), 64'hA);
        chk("tp5_data_last", 64'(d_end), 64'hA);

        // Reset during the response phase
        b0_control = 4'h5;
        axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_ARADDR = 16'h0000;
        step();
        axi.S_AXI_ARVALID = 1'b0;
        step();
        step();
        chk("tp6_rvalid_before", 64'(axi.S_AXI_RVALID), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("tp6_rvalid_async", 64'(axi.S_AXI_RVALID), 64'd0);
        chk("tp6_arready_async", 64'(axi.S_AXI_ARREADY), 64'd1);
        model_reset();
        step();
        #2 reset = 1'b1;
        do_read(16'h0000, 0, 1'b0, 1'b0, d, r, idx, lat, d_end);
        chk("tp6_after_data", 64'(d), 64'h5);
        chk("tp6_after_resp", 64'(r), 64'h0);

        // Randomized traffic, banks changing every cycle
        scramble_mode = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: a = {2'b00, 8'($urandom_range(0, 5)), 6'($urandom)};
                1: a = {2'b00, 8'($urandom), 6'($urandom)};
                2: a = {2'b01, 6'($urandom), 2'($urandom), 4'($urandom_range(0, 7)), 2'($urandom)};
                default: a = {2'($urandom_range(2, 3)), 14'($urandom)};
            endcase
            axi.S_AXI_ARVALID = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            do_read(a, int'($urandom_range(0, 3)), 1'b1, 1'b0, d, r, idx, lat, d_end);
        end
        scramble_mode = 0;
        axi.S_AXI_RREADY = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
